ascon_block_packer: RTL and testbench

// Upstream feeder for the ASCON-128 top_level core. Packs a byte stream into
// 64-bit rate blocks and applies ASCON 10* padding (0x80 then zeros). Drives
// the core's start_i/data_valid_i/data_i. Separates associated data (AD) and

---
 rtl/ascon_block_packer.sv | 214 +++++++++++++++++++++
 tb/tb_ascon_block_packer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_block_packer.sv
// Packs a byte stream into padded 64-bit ASCON rate blocks, split into AD and PT segments.
// Latency: data_valid_o rises one cycle after the byte that completes a block is accepted.
// Backpressure: bytes are refused while a block waits in OUT/PADBLK; block held until data_ready_i.
module ascon_block_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h80
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_pt_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  output logic        start_o,
  output logic [63:0] data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        block_pt_o,
  output logic        block_last_o,
  output logic        msg_end_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, FILL, OUT, PADBLK} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;            // index of the next byte within the block
  logic [63:0] shreg_q, shreg_d;        // block under construction
  logic        pt_q, pt_d;              // type of the block (type of its first byte)
  logic        last_q, last_d;          // block closes its segment
  logic        pad_pend_q, pad_pend_d;  // segment ended on a full block: pad block owed
  logic        seg_pt_q, seg_pt_d;      // message is in its PT segment
  logic        carry_vld_q, carry_vld_d;// PT byte that forced an early AD close
  logic [7:0]  carry_q, carry_d;
  logic        carry_last_q, carry_last_d;
  logic        msg_end_q, msg_end_d;
  logic        err_q, err_d;
  logic        rdy_en_q, rdy_en_d;      // keeps byte_ready_o low until the first edge after reset

  logic        accept;
  logic [2:0]  cnt_inc;
  logic [5:0]  lo, lo_pad;
  logic        wr, eff_pt;

  assign accept  = byte_valid_i & byte_ready_o;
  assign cnt_inc = cnt_q + 3'd1;
  // Byte k sits at bits [63-8k -: 8], i.e. its low bit is 8*(7-k) = {~k, 3'b000}.
  assign lo      = {~cnt_q, 3'b000};
  assign lo_pad  = {~cnt_inc, 3'b000};

  // State register and all datapath flops.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      shreg_q      <= 64'h0;
      pt_q         <= 1'b0;
      last_q       <= 1'b0;
      pad_pend_q   <= 1'b0;
      seg_pt_q     <= 1'b0;
      carry_vld_q  <= 1'b0;
      carry_q      <= 8'h0;
      carry_last_q <= 1'b0;
      msg_end_q    <= 1'b0;
      err_q        <= 1'b0;
      rdy_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      pt_q         <= pt_d;
      last_q       <= last_d;
      pad_pend_q   <= pad_pend_d;
      seg_pt_q     <= seg_pt_d;
      carry_vld_q  <= carry_vld_d;
      carry_q      <= carry_d;
      carry_last_q <= carry_last_d;
      msg_end_q    <= msg_end_d;
      err_q        <= err_d;
      rdy_en_q     <= rdy_en_d;
    end
  end

  // Next-state: byte packing, padding, segment tracking and block hand-off.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    pt_d         = pt_q;
    last_d       = last_q;
    pad_pend_d   = pad_pend_q;
    seg_pt_d     = seg_pt_q;
    carry_vld_d  = carry_vld_q;
    carry_d      = carry_q;
    carry_last_d = carry_last_q;
    msg_end_d    = 1'b0;
    err_d        = err_q;
    rdy_en_d     = 1'b1;
    wr           = 1'b0;
    eff_pt       = byte_pt_i;

    case (state_q)
      IDLE: begin
        if (accept) begin
          wr       = 1'b1;
          seg_pt_d = byte_pt_i;  // first byte PT means an empty AD segment
        end
      end
      FILL: begin
        if (accept) begin
          if (seg_pt_q) begin
            // Inside PT, an AD-tagged byte is taken as PT and flagged.
            wr     = 1'b1;
            eff_pt = 1'b1;
            if (!byte_pt_i) err_d = 1'b1;
          end else if (byte_pt_i) begin
            // PT arrived before the AD segment was closed: pad-close AD and
            // park the PT byte to open the next block.
            err_d        = 1'b1;
            shreg_d[lo +: 8] = PAD_BYTE;
            if (cnt_q == 3'd0) pt_d = 1'b0;
            last_d       = 1'b1;
            pad_pend_d   = 1'b0;
            cnt_d        = 3'd0;
            carry_vld_d  = 1'b1;
            carry_d      = byte_i;
            carry_last_d = byte_last_i;
            seg_pt_d     = 1'b1;
            state_d      = OUT;
          end else begin
            wr     = 1'b1;
            eff_pt = 1'b0;
          end
        end
      end
      OUT: begin
        if (data_ready_i) begin
          shreg_d = 64'h0;
          cnt_d   = 3'd0;
          if (pad_pend_q) begin
            pad_pend_d = 1'b0;
            last_d     = 1'b1;
            state_d    = PADBLK;
          end else if (carry_vld_q) begin
            carry_vld_d = 1'b0;
            shreg_d     = {carry_q, 56'h0};
            pt_d        = 1'b1;
            if (carry_last_q) begin
              shreg_d[55:48] = PAD_BYTE;
              last_d         = 1'b1;
              state_d        = OUT;
            end else begin
              cnt_d   = 3'd1;
              last_d  = 1'b0;
              state_d = FILL;
            end
          end else if (last_q && pt_q) begin
            msg_end_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = FILL;
          end
        end
      end
      PADBLK: begin
        if (data_ready_i) begin
          last_d = 1'b0;
          if (pt_q) begin
            msg_end_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Common write of an accepted byte into the current block.
    if (wr) begin
      shreg_d[lo +: 8] = byte_i;
      if (cnt_q == 3'd0) pt_d = eff_pt;
      cnt_d = cnt_inc;
      if (byte_last_i) begin
        if (cnt_q == 3'd7) begin
          pad_pend_d = 1'b1;
          last_d     = 1'b0;
        end else begin
          shreg_d[lo_pad +: 8] = PAD_BYTE;
          last_d               = 1'b1;
        end
        cnt_d   = 3'd0;
        state_d = OUT;
        if (!eff_pt) seg_pt_d = 1'b1;  // AD closed: only PT may follow
      end else if (cnt_q == 3'd7) begin
        last_d  = 1'b0;
        state_d = OUT;
      end else begin
        state_d = FILL;
      end
    end
  end

  assign byte_ready_o = rdy_en_q & ((state_q == IDLE) | (state_q == FILL));
  assign start_o      = accept & (state_q == IDLE);
  assign data_valid_o = (state_q == OUT) | (state_q == PADBLK);
  assign data_o       = (state_q == OUT)    ? shreg_q :
                        (state_q == PADBLK) ? {PAD_BYTE, 56'h0} : 64'h0;
  assign block_pt_o   = data_valid_o & pt_q;
  assign block_last_o = data_valid_o & last_q;
  assign msg_end_o    = msg_end_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_ascon_block_packer.sv
// Directed bench for ascon_block_packer: driver pushes expected blocks, monitor pops on handshake.
// Latency: checks block appears one cycle after its completing byte.
// Backpressure: stalls data_ready_i and checks the held block and refused bytes.
module tb_ascon_block_packer;

  logic        clk;
  logic        reset_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_pt_i;
  logic        byte_last_i;
  logic        byte_ready_o;
  logic        start_o;
  logic [63:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic        block_pt_o;
  logic        block_last_o;
  logic        msg_end_o;
  logic        err_o;

  typedef struct packed {
    logic [63:0] d;
    logic        pt;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   msg_cnt = 0;
  logic st;

  ascon_block_packer dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_pt_i    (byte_pt_i),
    .byte_last_i  (byte_last_i),
    .byte_ready_o (byte_ready_o),
    .start_o      (start_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .block_pt_o   (block_pt_o),
    .block_last_o (block_last_o),
    .msg_end_o    (msg_end_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic pt, input logic last);
    exp_t e;
    e.d = d; e.pt = pt; e.last = last;
    q.push_back(e);
  endtask

  // Present one byte, wait (bounded) for acceptance, report start_o at the accepting cycle.
  task automatic send(input logic [7:0] b, input logic pt, input logic last, output logic s);
    int n;
    n = 0;
    byte_i = b; byte_pt_i = pt; byte_last_i = last; byte_valid_i = 1'b1;
    @(negedge clk);
    while (!byte_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("byte_accept_timeout", {63'h0, byte_ready_o}, 64'h1);
    s = start_o;
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every output handshake must match the head of the queue.
  always @(negedge clk) begin
    if (!reset_i && data_valid_o && data_ready_i) begin
      if (q.size() == 0) begin
        chk("unexpected_block", data_o, 64'h0);
        chk("unexpected_block_valid", {63'h0, data_valid_o}, 64'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("block_data", data_o, e.d);
        chk("block_pt", {63'h0, block_pt_o}, {63'h0, e.pt});
        chk("block_last", {63'h0, block_last_o}, {63'h0, e.last});
      end
    end
    if (msg_end_o) msg_cnt++;
  end

  initial begin
    logic [7:0] t2a [8];
    logic [7:0] t2b [8];
    logic [7:0] t3  [8];
    int n;
    t2a = '{8'h43, 8'h6F, 8'h6E, 8'h63, 8'h65, 8'h76, 8'h65, 8'h7A};
    t2b = '{8'h20, 8'h41, 8'h53, 8'h43, 8'h4F, 8'h4E, 8'h20, 8'h65};
    t3  = '{8'h56, 8'h65, 8'h72, 8'h69, 8'h6C, 8'h6F, 8'h67, 8'h21};

    reset_i = 1'b1; byte_i = 8'h0; byte_valid_i = 1'b0; byte_pt_i = 1'b0;
    byte_last_i = 1'b0; data_ready_i = 1'b1;
    #12;
    chk("rst_valid", {63'h0, data_valid_o}, 64'h0);
    chk("rst_ready", {63'h0, byte_ready_o}, 64'h0);
    chk("rst_data", data_o, 64'h0);
    chk("rst_err", {63'h0, err_o}, 64'h0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    #1;
    chk("ready_before_edge", {63'h0, byte_ready_o}, 64'h0);
    @(posedge clk); #1;
    chk("ready_after_edge", {63'h0, byte_ready_o}, 64'h1);

    // 1: short AD segment, padded in-block
    push(64'h3230323380000000, 1'b0, 1'b1);
    send(8'h32, 1'b0, 1'b0, st);
    chk("t1_start", {63'h0, st}, 64'h1);
    send(8'h30, 1'b0, 1'b0, st);
    send(8'h32, 1'b0, 1'b0, st);
    send(8'h33, 1'b0, 1'b1, st);
    chk("t1_latency_valid", {63'h0, data_valid_o}, 64'h1);

    // 2: two full PT blocks
    push(64'h436F6E636576657A, 1'b1, 1'b0);
    push(64'h204153434F4E2065, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(t2a[i], 1'b1, 1'b0, st);
      if (i == 0) chk("t2_no_restart", {63'h0, st}, 64'h0);
    end
    for (int i = 0; i < 8; i++) send(t2b[i], 1'b1, 1'b0, st);

    // 3: PT ends exactly on a block boundary -> extra pad block
    push(64'h566572696C6F6721, 1'b1, 1'b0);
    push(64'h8000000000000000, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) send(t3[i], 1'b1, i == 7, st);
    settle();
    chk("t3_msg_end", msg_cnt, 1);
    chk("t3_idle_ready", {63'h0, byte_ready_o}, 64'h1);

    // 4: stall the consumer for 5 cycles with a byte waiting
    data_ready_i = 1'b0;
    push(64'h0102030405060708, 1'b1, 1'b0);
    push(64'h0980000000000000, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b1, 1'b0, st);
    byte_i = 8'h09; byte_pt_i = 1'b1; byte_last_i = 1'b1; byte_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_stall_data", data_o, 64'h0102030405060708);
      chk("t4_stall_ready", {63'h0, byte_ready_o}, 64'h0);
    end
    data_ready_i = 1'b1;
    send(8'h09, 1'b1, 1'b1, st);
    settle();
    chk("t4_msg_end", msg_cnt, 2);

    // 5: empty AD segment
    push(64'hAA80000000000000, 1'b1, 1'b1);
    send(8'hAA, 1'b1, 1'b1, st);
    chk("t5_start", {63'h0, st}, 64'h1);
    settle();
    chk("t5_msg_end", msg_cnt, 3);
    chk("t5_err_clear", {63'h0, err_o}, 64'h0);

    // 6: reset mid-FILL, then protocol errors
    send(8'h11, 1'b0, 1'b0, st);
    send(8'h22, 1'b0, 1'b0, st);
    send(8'h33, 1'b0, 1'b0, st);
    reset_i = 1'b1;
    #1;
    chk("t6_rst_ready", {63'h0, byte_ready_o}, 64'h0);
    chk("t6_rst_valid", {63'h0, data_valid_o}, 64'h0);
    chk("t6_rst_data", data_o, 64'h0);
    #10;
    reset_i = 1'b0;
    push(64'h4480000000000000, 1'b0, 1'b1);
    send(8'h44, 1'b0, 1'b1, st);
    chk("t6_restart", {63'h0, st}, 64'h1);
    push(64'h5566778000000000, 1'b1, 1'b1);
    send(8'h55, 1'b1, 1'b0, st);
    send(8'h66, 1'b0, 1'b0, st);
    send(8'h77, 1'b1, 1'b1, st);
    settle();
    chk("t6_err_set", {63'h0, err_o}, 64'h1);
    // PT byte before AD closed: AD pad-closed, PT byte opens the next block
    push(64'h0180000000000000, 1'b0, 1'b1);
    push(64'h0280000000000000, 1'b1, 1'b1);
    send(8'h01, 1'b0, 1'b0, st);
    send(8'h02, 1'b1, 1'b1, st);
    settle();
    chk("t6_err_sticky", {63'h0, err_o}, 64'h1);
    chk("t6_msg_end", msg_cnt, 5);

    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
